// File: rtl/dm_preload_ctrl.sv
// Upstream feeder and run controller for the 9-bit core: streams operands into data
// memory, writes the preset constants, clears the rest, runs the core and reads back Min/Max.
module dm_preload_ctrl #(
  parameter int NOPS     = 64,
  parameter int PRE_BASE = 64,
  parameter int CLR_BASE = 72,
  parameter int DM_TOP   = 255,
  parameter int MASK_CYC = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       go,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       dm_we,
  output logic [7:0] dm_addr,
  output logic [7:0] dm_wdata,
  input  logic [7:0] dm_rdata,
  output logic       core_reset,
  input  logic       core_done,
  output logic       res_valid,
  output logic [4:0] res_min,
  output logic [4:0] res_max,
  output logic       res_err,
  output logic       busy
);

  localparam int         MW        = $clog2(MASK_CYC + 1);
  localparam logic [7:0] LAST_OP   = 8'(NOPS - 1);
  localparam logic [7:0] PRE_ADDR  = 8'(PRE_BASE);
  localparam logic [7:0] MAX_ADDR  = 8'(PRE_BASE + 1);
  localparam logic [7:0] PRE_LAST  = 8'(CLR_BASE - 1);
  localparam logic [7:0] CLR_ADDR  = 8'(CLR_BASE);
  localparam logic [7:0] TOP_ADDR  = 8'(DM_TOP);
  localparam logic [7:0] RES_LIMIT = 8'd16;

  typedef enum logic [2:0] {
    IDLE, LOAD, PRESET, CLEAR, RELEASE, RUN, RD_MIN, RD_MAX
  } state_t;

  state_t          state_reg;
  logic [7:0]      cnt_reg;
  logic [MW-1:0]   mask_reg;
  logic [7:0]      min_raw_reg;
  logic            xfer;
  logic [2:0]      pre_off;

  assign xfer    = in_valid && in_ready;
  assign pre_off = 3'(cnt_reg - PRE_ADDR);

  function automatic logic [7:0] preset_byte(input logic [2:0] idx);
    logic [7:0] val;
    case (idx)
      3'd0:    val = 8'd16;
      3'd1:    val = 8'd0;
      3'd2:    val = 8'd1;
      3'd3:    val = 8'd5;
      3'd4:    val = 8'd15;
      3'd5:    val = 8'd47;
      3'd6:    val = 8'd93;
      default: val = 8'd115;
    endcase
    return val;
  endfunction

  // Memory port is combinational so a stream byte lands in the same cycle it is accepted.
  always_comb begin
    dm_we    = 1'b0;
    dm_addr  = '0;
    dm_wdata = '0;
    case (state_reg)
      LOAD: begin
        dm_we    = xfer;
        dm_addr  = cnt_reg;
        dm_wdata = in_data;
      end
      PRESET: begin
        dm_we    = 1'b1;
        dm_addr  = cnt_reg;
        dm_wdata = preset_byte(pre_off);
      end
      CLEAR: begin
        dm_we    = 1'b1;
        dm_addr  = cnt_reg;
      end
      RD_MIN:  dm_addr = PRE_ADDR;
      RD_MAX:  dm_addr = MAX_ADDR;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      mask_reg    <= '0;
      min_raw_reg <= '0;
      in_ready    <= 1'b0;
      core_reset  <= 1'b1;
      res_valid   <= 1'b0;
      res_min     <= '0;
      res_max     <= '0;
      res_err     <= 1'b0;
      busy        <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (go) begin
            res_valid <= 1'b0;
            res_min   <= '0;
            res_max   <= '0;
            res_err   <= 1'b0;
            cnt_reg   <= '0;
            in_ready  <= 1'b1;
            busy      <= 1'b1;
            state_reg <= LOAD;
          end
        end
        LOAD: begin
          if (xfer) begin
            if (cnt_reg == LAST_OP) begin
              in_ready  <= 1'b0;
              cnt_reg   <= PRE_ADDR;
              state_reg <= PRESET;
            end else begin
              cnt_reg <= cnt_reg + 8'd1;
            end
          end
        end
        PRESET: begin
          if (cnt_reg == PRE_LAST) begin
            cnt_reg   <= CLR_ADDR;
            state_reg <= CLEAR;
          end else begin
            cnt_reg <= cnt_reg + 8'd1;
          end
        end
        CLEAR: begin
          // Compare before incrementing so the 8-bit address never wraps past the top.
          if (cnt_reg == TOP_ADDR) begin
            cnt_reg    <= '0;
            core_reset <= 1'b0;
            state_reg  <= RELEASE;
          end else begin
            cnt_reg <= cnt_reg + 8'd1;
          end
        end
        RELEASE: begin
          mask_reg  <= MW'(MASK_CYC);
          state_reg <= RUN;
        end
        RUN: begin
          if (mask_reg != '0) begin
            mask_reg <= mask_reg - MW'(1);
          end else if (core_done) begin
            core_reset <= 1'b1;
            state_reg  <= RD_MIN;
          end
        end
        RD_MIN: begin
          res_min     <= dm_rdata[4:0];
          min_raw_reg <= dm_rdata;
          state_reg   <= RD_MAX;
        end
        RD_MAX: begin
          res_max   <= dm_rdata[4:0];
          res_err   <= (min_raw_reg > RES_LIMIT) || (dm_rdata > RES_LIMIT) ||
                       (min_raw_reg > dm_rdata);
          res_valid <= 1'b1;
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_preload_ctrl.sv
// Bench for dm_preload_ctrl: memory plus core model, write scoreboard built from the
// expected memory image, and per-run checks of latency, mask window and results.
module tb_dm_preload_ctrl;

  localparam int MASK_CYC = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       go;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       dm_we;
  logic [7:0] dm_addr;
  logic [7:0] dm_wdata;
  logic [7:0] dm_rdata;
  logic       core_reset;
  logic       core_done;
  logic       res_valid;
  logic [4:0] res_min;
  logic [4:0] res_max;
  logic       res_err;
  logic       busy;

  int total = 0;
  int bad   = 0;

  logic [7:0]  mem     [256];
  logic [7:0]  stream  [64];
  logic [7:0]  presets [8];
  logic [15:0] exp_q   [$];

  logic       scramble;
  logic       stuck;
  int         core_delay;
  int         core_cnt;
  logic [7:0] core_min;
  logic [7:0] core_max;

  dm_preload_ctrl #(
    .NOPS(64), .PRE_BASE(64), .CLR_BASE(72), .DM_TOP(255), .MASK_CYC(MASK_CYC)
  ) dut (
    .clk(clk), .reset(reset), .go(go), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .core_reset(core_reset), .core_done(core_done),
    .res_valid(res_valid), .res_min(res_min), .res_max(res_max), .res_err(res_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  assign dm_rdata = mem[dm_addr];

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  // Memory and core model: the core writes Min/Max after core_delay released cycles, then raises done.
  always @(posedge clk) begin
    if (scramble) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'($urandom);
    end else if (dm_we) begin
      mem[dm_addr] <= dm_wdata;
    end
    if (core_reset) begin
      core_cnt  <= 0;
      core_done <= stuck;
    end else begin
      core_cnt <= core_cnt + 1;
      if (core_cnt == core_delay) begin
        mem[64]   <= core_min;
        mem[65]   <= core_max;
        core_done <= 1'b1;
      end else if (stuck) begin
        core_done <= 1'b1;
      end
    end
  end

  // Every write must match the next entry of the expected memory image, in order.
  always @(negedge clk) begin
    if (reset) begin
      if (dm_we) begin
        if (exp_q.size() == 0) begin
          chk("extra_write", {24'd0, dm_addr}, 32'hFFFF);
        end else begin
          logic [15:0] e;
          e = exp_q.pop_front();
          chk("wr_addr", dm_addr, e[15:8]);
          chk("wr_data", dm_wdata, e[7:0]);
        end
      end
      if (!busy) chk("idle_quiet", {dm_we, in_ready}, 0);
      if (!core_reset) chk("no_write_in_run", dm_we, 0);
    end
  end

  task automatic do_run(input bit toggle, input bit incr, input int delay, input bit stk,
                        input logic [7:0] vmin, input logic [7:0] vmax, input bit go_at_exit);
    int n, idx, rel, m, exp_rel, exp_lat, bad_mem;
    bit acc, vtog, seen_drop;
    logic eerr;
    core_delay = delay;
    core_min   = vmin;
    core_max   = vmax;
    stuck      = stk;
    for (int i = 0; i < 64; i++) stream[i] = incr ? 8'(i) : 8'($urandom);
    exp_q.delete();
    for (int i = 0; i < 64; i++) exp_q.push_back({8'(i), stream[i]});
    for (int i = 0; i < 8; i++) exp_q.push_back({8'(64 + i), presets[i]});
    for (int i = 72; i < 256; i++) exp_q.push_back({8'(i), 8'h00});
    scramble = 1'b1;
    @(posedge clk); #1;
    scramble = 1'b0;

    go = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    go = 1'b0;
    chk("go_clears_valid", res_valid, 0);
    chk("go_clears_err", res_err, 0);
    chk("go_busy", busy, 1);
    chk("go_ready", in_ready, 1);
    chk("go_core_held", core_reset, 1);

    n = 1; idx = 0; vtog = 1'b0; seen_drop = 1'b0;
    while (core_reset !== 1'b0 && n < 2000) begin
      if (idx < 64) begin
        in_valid = toggle ? vtog : 1'b1;
        in_data  = in_valid ? stream[idx] : 8'($urandom);
      end else begin
        in_valid = 1'b1;
        in_data  = 8'hA5;
        if (!seen_drop) begin
          chk("ready_after_last", in_ready, 0);
          seen_drop = 1'b1;
        end
      end
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      n++;
      vtog = !vtog;
      if (acc) idx++;
    end
    in_valid = 1'b0;
    exp_lat = toggle ? 2 * 64 + 193 : 257;
    chk("release_latency", n, exp_lat);
    chk("bytes_accepted", idx, 64);

    rel = 0; m = 0;
    while (core_reset === 1'b0 && m < 5000) begin
      rel++;
      go = (m == 2);
      @(posedge clk); #1;
      m++;
    end
    go = 1'b0;
    exp_rel = stk ? MASK_CYC + 2
                  : (((delay + 1) > (MASK_CYC + 1)) ? delay + 1 : MASK_CYC + 1) + 1;
    chk("release_window", rel, exp_rel);
    chk("rdmin_busy", busy, 1);
    chk("rdmin_no_valid", res_valid, 0);

    @(posedge clk); #1;
    go = go_at_exit;
    @(posedge clk); #1;
    go = 1'b0;
    eerr = (vmin > 8'd16) || (vmax > 8'd16) || (vmin > vmax);
    chk("res_valid", res_valid, 1);
    chk("res_min", res_min, vmin[4:0]);
    chk("res_max", res_max, vmax[4:0]);
    chk("res_err", res_err, eerr);
    chk("done_busy", busy, 0);
    chk("done_core_held", core_reset, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("res_held", res_valid, 1);
    chk("stay_idle", busy, 0);
    chk("writes_left", exp_q.size(), 0);

    bad_mem = 0;
    for (int i = 0; i < 64; i++) if (mem[i] !== stream[i]) bad_mem++;
    chk("mem_operands", bad_mem, 0);
    bad_mem = 0;
    for (int i = 72; i < 256; i++) if (mem[i] !== 8'h00) bad_mem++;
    chk("mem_cleared", bad_mem, 0);
    chk("mem_preset66", mem[66], 8'd1);
    chk("mem_preset67", mem[67], 8'd5);
    chk("mem_preset68", mem[68], 8'd15);
    chk("mem_preset69", mem[69], 8'd47);
    chk("mem_preset70", mem[70], 8'd93);
    chk("mem_preset71", mem[71], 8'd115);
    $display("run toggle=%0d delay=%0d stuck=%0d min=%0d max=%0d latency=%0d window=%0d err=%0d",
             toggle, delay, stk, vmin, vmax, n, rel, res_err);
  endtask

  task automatic abort_mid_load();
    int idx;
    bit acc;
    for (int i = 0; i < 64; i++) stream[i] = 8'($urandom);
    exp_q.delete();
    for (int i = 0; i < 64; i++) exp_q.push_back({8'(i), stream[i]});
    go = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    go = 1'b0;
    idx = 0;
    in_valid = 1'b1;
    while (idx < 10) begin
      in_data = stream[idx];
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) idx++;
    end
    reset = 1'b0;
    #1;
    exp_q.delete();
    chk("abort_core_held", core_reset, 1);
    chk("abort_busy", busy, 0);
    chk("abort_ready", in_ready, 0);
    chk("abort_we", dm_we, 0);
    chk("abort_valid", res_valid, 0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("abort_stays_idle", busy, 0);
    in_valid = 1'b0;
    $display("abort after %0d bytes", idx);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; go = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    scramble = 1'b0; stuck = 1'b0; core_delay = 0; core_min = 8'h00; core_max = 8'h00;
    presets = '{8'd16, 8'd0, 8'd1, 8'd5, 8'd15, 8'd47, 8'd93, 8'd115};
    #3 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_core_reset", core_reset, 1);
    chk("rst_busy", busy, 0);
    chk("rst_ready", in_ready, 0);
    chk("rst_we", dm_we, 0);
    chk("rst_addr", dm_addr, 0);
    chk("rst_wdata", dm_wdata, 0);
    chk("rst_valid", res_valid, 0);
    chk("rst_min", res_min, 0);
    chk("rst_max", res_max, 0);
    chk("rst_err", res_err, 0);
    reset = 1'b1;
    @(posedge clk); #1;

    abort_mid_load();
    do_run(1'b1, 1'b1, 500, 1'b0, 8'd3, 8'd13, 1'b1);
    do_run(1'b0, 1'b0, 0, 1'b1, 8'd14, 8'd9, 1'b0);
    for (int r = 0; r < 2; r++) begin
      do_run(1'b0, 1'b0, int'($urandom_range(0, 10)), 1'b0,
             8'($urandom_range(0, 31)), 8'($urandom_range(0, 31)), 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dm_preload_ctrl.md
Name: dm_preload_ctrl

Overview:
- Upstream feeder and run controller for the 9-bit processor `top_level`.
- Accepts program-1 operands as a byte stream and writes them into data memory at [0:63]. Writes the fixed preset constants to [64:71] and zeroes [72:255].
- Holds the core in reset during loading, then releases it and waits for the core's `done`.
- Reads back Min from [64] and Max from [65], and presents them with a valid flag.

Parameters:
- NOPS, 64, number of operand bytes streamed in (32 16-bit operands, high byte first, one address each).
- PRE_BASE, 64, first preset address.
- CLR_BASE, 72, first address zeroed.
- DM_TOP, 255, last data-memory address.
- MASK_CYC, 4, cycles after core release during which `core_done` is ignored.

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-low reset.
- go  in  1  single-cycle pulse that starts a load/run sequence; honoured only in IDLE.
- in_valid  in  1  stream byte valid.
- in_data  in  8  stream byte.
- in_ready  out  1  stream ready; a transfer occurs when in_valid and in_ready are both 1.
- dm_we  out  1  data-memory write enable.
- dm_addr  out  8  data-memory address.
- dm_wdata  out  8  data-memory write data.
- dm_rdata  in  8  data-memory read data; combinational with dm_addr.
- core_reset  out  1  drives the core's active-high reset; 1 holds the core.
- core_done  in  1  core completion flag.
- res_valid  out  1  result valid; held until the next accepted go.
- res_min  out  5  dm[64][4:0].
- res_max  out  5  dm[65][4:0].
- res_err  out  1  set if dm[64]>16, dm[65]>16, or dm[64]>dm[65].
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (reset=0, asynchronous), all regardless of current state:
  - State=IDLE, core_reset=1.
  - in_ready=0, dm_we=0, dm_addr=0, dm_wdata=0.
  - res_valid=0, res_min=0, res_max=0, res_err=0, busy=0.
  - All counters cleared. Any in-flight sequence is abandoned; no partial result is reported.
- States: IDLE -> LOAD -> PRESET -> CLEAR -> RELEASE -> RUN -> RD_MIN -> RD_MAX -> IDLE.
- IDLE:
  - core_reset=1.
  - On go: clear res_valid/res_min/res_max/res_err and the address counter, then enter LOAD.
- LOAD:
  - in_ready=1.
  - Each transfer: dm_we=1, dm_addr=cnt, dm_wdata=in_data, cnt++; writes happen in the same cycle as the transfer.
  - in_valid=0 stalls indefinitely with no write.
  - After transfer NOPS-1 (cnt wraps to 64), the next state is PRESET and in_ready drops the following cycle. Byte 65 is never accepted.
- PRESET:
  - One write per cycle for 8 cycles, addresses 64..71.
  - Data in order: 16, 0, 1, 5, 15, 47, 93, 115.
  - in_ready=0.
- CLEAR:
  - One write per cycle, addresses CLR_BASE..DM_TOP, data 0 (184 cycles).
  - The 8-bit address must not wrap past 255. Exit after writing 255.
- RELEASE:
  - One cycle, dm_we=0, core_reset=0.
  - Load a mask counter with MASK_CYC.
- RUN:
  - core_reset=0.
  - core_done is ignored while the mask counter is non-zero; the counter decrements each cycle.
  - The first core_done=1 seen with the counter at zero moves to RD_MIN. Assert core_reset=1 in the same transition so the core halts.
  - No timeout.
- RD_MIN:
  - dm_addr=64, dm_we=0.
  - Capture res_min=dm_rdata[4:0] and the raw byte.
- RD_MAX:
  - dm_addr=65.
  - Capture res_max, compute res_err, and set res_valid=1 on the clock edge that leaves RD_MAX.
- dm_we is never asserted outside LOAD, PRESET and CLEAR.
- Write count per run: exactly 64 in LOAD, 8 in PRESET, 184 in CLEAR.
- go asserted while busy is ignored. A go arriving in the same cycle as the RD_MAX exit is ignored.
- core_done=1 held high from the previous run is masked by MASK_CYC. If it is still high after the mask expires, it is treated as done (the core owns its done semantics).
- Latency from go to core release, with in_valid held at 1: 64 + 8 + 184 + 1 = 257 cycles.

Test Plan:
- Reset mid-LOAD: reset=0 after 10 bytes -> state IDLE, core_reset=1, busy=0 immediately, no further dm writes. A following go restarts at address 0.
- Stream 64 bytes 0x00..0x3F with in_valid toggling every other cycle -> dm[i]=i for i=0..63, exactly 64 writes, in_ready=0 after byte 63, byte 64 not accepted.
- Full run, in_valid constant 1 -> core_reset falls exactly 257 cycles after go.
  - dm[64..71] = 16, 0, 1, 5, 15, 47, 93, 115.
  - dm[72..255] = 0.
- Behavioural memory/core model returns done after 500 cycles with dm[64]=3, dm[65]=13 -> res_min=3, res_max=13, res_err=0, res_valid=1, core_reset=1, state IDLE.
- core_done stuck at 1 from release -> no exit before MASK_CYC=4 cycles. Transition to RD_MIN occurs on the cycle after the mask reaches 0.
- Model writes dm[64]=14, dm[65]=9 -> res_err=1, res_valid=1. A second go clears res_valid and restarts LOAD.
